video_ctrl_regs: RTL and testbench

Avalon-MM responder on the FPGA side of the HPS-FPGA bridge, exposing the video pipeline's control and status registers to software. It decodes single-word reads and writes from the bridge, drives the enable and solid-fill colour into the pixel path, and reports synchronised HDMI hot-plug state and a frame counter advanced by the pixel cursor's vsync. It sits between the bridge pins and the video generator, clocked by the pixel clock that is also forwarded to the bridge.

---
 rtl/video_regs_pkg.sv | 27 ++
 rtl/sync_edge.sv | 25 ++
 rtl/video_ctrl_regs.sv | 103 ++++++++++
 tb/tb_video_ctrl_regs.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_regs_pkg.sv
// Shared register map, bit positions and defaults for the video control/status block.
package video_regs_pkg;
  localparam int ADDR_W = 19;

  localparam logic [ADDR_W-1:0] ADDR_ID          = 19'h0;
  localparam logic [ADDR_W-1:0] ADDR_CTRL        = 19'h1;
  localparam logic [ADDR_W-1:0] ADDR_COLOUR      = 19'h2;
  localparam logic [ADDR_W-1:0] ADDR_STATUS      = 19'h3;
  localparam logic [ADDR_W-1:0] ADDR_FRAME_COUNT = 19'h4;
  localparam logic [ADDR_W-1:0] ADDR_SCRATCH     = 19'h5;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_CNT_EN  = 1;
  localparam int STAT_HPD_LVL = 0;
  localparam int STAT_HPD_CHG = 1;
  localparam int STAT_VSYNC   = 2;

  localparam logic [31:0] ID_DEFAULT     = 32'h4C41_4250;
  localparam logic [23:0] COLOUR_DEFAULT = 24'h00FF00;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              rd;
    logic              wr;
    logic [31:0]       wdata;
  } avs_req_t;
endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser with a registered previous value and an any-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic q_prev,
  output logic edge_pulse
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      q      <= 1'b0;
      q_prev <= 1'b0;
    end else begin
      meta   <= d;
      q      <= meta;
      q_prev <= q;
    end
  end

  assign edge_pulse = q ^ q_prev;
endmodule

// File: rtl/video_ctrl_regs.sv
// Avalon-MM control/status registers for the video pipeline, single pix_clk domain.
module video_ctrl_regs
  import video_regs_pkg::*;
#(
  parameter logic [31:0] ID_VALUE     = ID_DEFAULT,
  parameter logic [23:0] COLOUR_RESET = COLOUR_DEFAULT
) (
  input  logic              pix_clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  input  logic              hpd,
  input  logic              vsync,
  output logic              video_enable,
  output logic [23:0]       fg_colour
);
  avs_req_t    req;
  logic [1:0]  ctrl;
  logic [23:0] colour;
  logic        hpd_changed;
  logic [31:0] frame_count;
  logic [31:0] scratch;
  logic        vsync_q;
  logic        hpd_level, hpd_prev, hpd_edge;
  logic        vsync_rise;
  logic [31:0] rd_mux;
  logic        unused_hpd_prev;

  assign req = '{addr: avs_address, rd: avs_read, wr: avs_write, wdata: avs_writedata};

  sync_edge u_hpd_sync (
    .clk       (pix_clk),
    .rst_n     (reset_n),
    .d         (hpd),
    .q         (hpd_level),
    .q_prev    (hpd_prev),
    .edge_pulse(hpd_edge)
  );
  assign unused_hpd_prev = hpd_prev;

  // vsync is already in pix_clk, so one flop is enough for rise detection
  assign vsync_rise = vsync & ~vsync_q;

  always_comb begin
    rd_mux = '0;
    case (req.addr)
      ADDR_ID:          rd_mux = ID_VALUE;
      ADDR_CTRL:        rd_mux = {30'b0, ctrl};
      ADDR_COLOUR:      rd_mux = {8'b0, colour};
      ADDR_STATUS: begin
        rd_mux[STAT_HPD_LVL] = hpd_level;
        rd_mux[STAT_HPD_CHG] = hpd_changed;
        rd_mux[STAT_VSYNC]   = vsync;
      end
      ADDR_FRAME_COUNT: rd_mux = frame_count;
      ADDR_SCRATCH:     rd_mux = scratch;
      default:          rd_mux = '0;
    endcase
  end

  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl        <= '0;
      colour      <= COLOUR_RESET;
      hpd_changed <= 1'b0;
      frame_count <= '0;
      scratch     <= '0;
      vsync_q     <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (req.wr && req.addr == ADDR_CTRL)    ctrl    <= req.wdata[1:0];
      if (req.wr && req.addr == ADDR_COLOUR)  colour  <= req.wdata[23:0];
      if (req.wr && req.addr == ADDR_SCRATCH) scratch <= req.wdata;
      // a new edge outranks a coincident W1C
      if (hpd_edge)
        hpd_changed <= 1'b1;
      else if (req.wr && req.addr == ADDR_STATUS && req.wdata[STAT_HPD_CHG])
        hpd_changed <= 1'b0;
      if (req.wr && req.addr == ADDR_FRAME_COUNT)
        frame_count <= '0;
      else if (vsync_rise && ctrl[CTRL_CNT_EN])
        frame_count <= frame_count + 32'd1;
    end
  end

  // read data sampled from pre-write state, so a same-cycle write is not visible
  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      avs_readdatavalid <= req.rd;
      if (req.rd) avs_readdata <= rd_mux;
    end
  end

  assign video_enable = ctrl[CTRL_EN];
  assign fg_colour    = colour;
endmodule

// File: tb/tb_video_ctrl_regs.sv
// Randomised self-checking bench for video_ctrl_regs against a register-map model.
module tb_video_ctrl_regs;
  logic        pix_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [18:0] avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        hpd = 1'b0;
  logic        vsync = 1'b0;
  logic        video_enable;
  logic [23:0] fg_colour;

  int n_pass = 0;
  int n_total = 0;

  // register-level model
  bit [1:0]  m_ctrl;
  bit [23:0] m_colour;
  bit        m_chg, m_lvl;
  bit [31:0] m_count, m_scratch;

  video_ctrl_regs dut (
    .pix_clk(pix_clk), .reset_n(reset_n),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .hpd(hpd), .vsync(vsync),
    .video_enable(video_enable), .fg_colour(fg_colour)
  );

  always #5 pix_clk = ~pix_clk;

  function automatic void model_reset();
    m_ctrl = 0; m_colour = 24'h00FF00; m_chg = 0; m_lvl = 0; m_count = 0; m_scratch = 0;
  endfunction

  function automatic logic [31:0] model_read(logic [18:0] a);
    case (a)
      19'd0:   return 32'h4C41_4250;
      19'd1:   return {30'b0, m_ctrl};
      19'd2:   return {8'b0, m_colour};
      19'd3:   return {29'b0, vsync, m_chg, m_lvl};
      19'd4:   return m_count;
      19'd5:   return m_scratch;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_write(logic [18:0] a, logic [31:0] d);
    case (a)
      19'd1: m_ctrl = d[1:0];
      19'd2: m_colour = d[23:0];
      19'd3: if (d[1]) m_chg = 0;
      19'd4: m_count = 0;
      19'd5: m_scratch = d;
      default: ;
    endcase
  endfunction

  // all bus tasks start and end on a falling edge
  task automatic do_access(input logic [18:0] a, input bit rd, input bit wr, input logic [31:0] wd,
                           output logic [31:0] rdata, output logic vld);
    avs_address = a; avs_read = rd; avs_write = wr; avs_writedata = wd;
    @(negedge pix_clk);
    avs_read = 1'b0; avs_write = 1'b0;
    rdata = avs_readdata; vld = avs_readdatavalid;
    if (wr) model_write(a, wd);
  endtask

  task automatic do_read(input logic [18:0] a, output logic [31:0] rdata, output logic vld);
    do_access(a, 1'b1, 1'b0, 32'h0, rdata, vld);
  endtask

  task automatic do_write(input logic [18:0] a, input logic [31:0] d);
    logic [31:0] rd; logic v;
    do_access(a, 1'b0, 1'b1, d, rd, v);
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    @(negedge pix_clk);
    vsync = 1'b0;
    @(negedge pix_clk);
    if (m_ctrl[1]) m_count = m_count + 32'd1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic v;
    logic [18:0] addrs [4] = '{19'd0, 19'd1, 19'd2, 19'd5};
    logic [31:0] exps  [4] = '{32'h4C41_4250, 32'h0, 32'h0000_FF00, 32'h0};
    reset_n = 1'b0;
    repeat (2) @(negedge pix_clk);
    reset_n = 1'b1;
    model_reset();
    @(negedge pix_clk);
    n_total++; if (avs_readdatavalid !== 1'b0 || avs_readdata !== 32'h0)
      $display("FAIL reset_rd: vld %b data %h, want 0/0", avs_readdatavalid, avs_readdata); else n_pass++;
    n_total++; if (video_enable !== 1'b0 || fg_colour !== 24'h00FF00)
      $display("FAIL reset_out: en %b colour %h, want 0/00ff00", video_enable, fg_colour); else n_pass++;
    foreach (addrs[i]) begin
      do_read(addrs[i], rd, v);
      n_total++; if (v !== 1'b1 || rd !== exps[i])
        $display("FAIL reset_read[%0h]: vld %b data %h, want 1/%h", addrs[i], v, rd, exps[i]); else n_pass++;
    end
    @(negedge pix_clk);
    n_total++; if (avs_readdatavalid !== 1'b0)
      $display("FAIL vld_one_cycle: vld %b, want 0", avs_readdatavalid); else n_pass++;
  endtask

  task automatic test_colour_ctrl();
    logic [31:0] rd; logic v;
    do_write(19'd2, 32'hAB12_3456);
    n_total++; if (fg_colour !== 24'h123456)
      $display("FAIL fg_colour: got %h want 123456", fg_colour); else n_pass++;
    do_read(19'd2, rd, v);
    n_total++; if (v !== 1'b1 || rd !== 32'h0012_3456)
      $display("FAIL colour_read: got %h vld %b want 00123456", rd, v); else n_pass++;
    do_write(19'd1, 32'h1);
    n_total++; if (video_enable !== 1'b1)
      $display("FAIL video_enable: got %b want 1", video_enable); else n_pass++;
  endtask

  task automatic test_frame_count();
    logic [31:0] rd; logic v;
    do_write(19'd1, 32'h2);
    repeat (5) vsync_pulse();
    do_read(19'd4, rd, v);
    n_total++; if (rd !== m_count || rd !== 32'd5)
      $display("FAIL count5: got %h want %h", rd, m_count); else n_pass++;
    force dut.frame_count = 32'hFFFF_FFFF;
    #1 release dut.frame_count;
    m_count = 32'hFFFF_FFFF;
    vsync_pulse();
    do_read(19'd4, rd, v);
    n_total++; if (rd !== m_count)
      $display("FAIL count_wrap: got %h want %h", rd, m_count); else n_pass++;
    repeat (2) vsync_pulse();
    // clear coincident with a vsync rise
    vsync = 1'b1;
    do_write(19'd4, $urandom);
    vsync = 1'b0;
    @(negedge pix_clk);
    do_read(19'd4, rd, v);
    n_total++; if (rd !== 32'h0)
      $display("FAIL count_clr_coinc: got %h want 0", rd); else n_pass++;
    do_write(19'd1, 32'h0);
    vsync = 1'b1;
    do_read(19'd3, rd, v);
    n_total++; if (rd !== 32'h4)
      $display("FAIL status_vsync_live: got %h want 4", rd); else n_pass++;
    vsync = 1'b0;
    @(negedge pix_clk);
    do_read(19'd4, rd, v);
    n_total++; if (rd !== m_count)
      $display("FAIL count_disabled: got %h want %h", rd, m_count); else n_pass++;
  endtask

  task automatic test_hpd();
    logic [31:0] rd; logic v;
    hpd = 1'b1;
    repeat (2) @(negedge pix_clk);
    do_read(19'd3, rd, v);
    n_total++; if (rd !== 32'h1)
      $display("FAIL hpd_level_2cyc: got %h want 1", rd); else n_pass++;
    m_lvl = 1; m_chg = 1;
    do_read(19'd3, rd, v);
    n_total++; if (rd !== 32'h3)
      $display("FAIL hpd_changed_3cyc: got %h want 3", rd); else n_pass++;
    do_write(19'd3, 32'h2);
    do_read(19'd3, rd, v);
    n_total++; if (rd !== model_read(19'd3) || rd !== 32'h1)
      $display("FAIL hpd_w1c: got %h want 1", rd); else n_pass++;
    // W1C lands on the cycle the falling edge sets the sticky bit
    hpd = 1'b0;
    repeat (2) @(negedge pix_clk);
    do_write(19'd3, 32'h2);
    m_lvl = 0; m_chg = 1;
    do_read(19'd3, rd, v);
    n_total++; if (rd !== 32'h2)
      $display("FAIL hpd_w1c_coinc: got %h want 2", rd); else n_pass++;
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; logic v;
    do_write(19'd5, 32'hCAFE_F00D);
    do_read(19'd7, rd, v);
    n_total++; if (v !== 1'b1 || rd !== 32'h0)
      $display("FAIL read_0x7: got %h vld %b want 0", rd, v); else n_pass++;
    do_read(19'h40000, rd, v);
    n_total++; if (v !== 1'b1 || rd !== 32'h0)
      $display("FAIL read_0x40000: got %h vld %b want 0", rd, v); else n_pass++;
    do_write(19'd6, $urandom);
    for (int a = 0; a < 6; a++) begin
      do_read(19'(a), rd, v);
      n_total++; if (rd !== model_read(19'(a)))
        $display("FAIL unmapped_write_reg%0d: got %h want %h", a, rd, model_read(19'(a))); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [3];
    logic [18:0] addrs [3] = '{19'd0, 19'd5, 19'd0};
    foreach (addrs[i]) exp[i] = model_read(addrs[i]);
    avs_read = 1'b1;
    foreach (addrs[i]) begin
      avs_address = addrs[i];
      @(negedge pix_clk);
      if (i == 2) avs_read = 1'b0;
      n_total++; if (avs_readdatavalid !== 1'b1 || avs_readdata !== exp[i])
        $display("FAIL b2b[%0d]: vld %b data %h want 1/%h", i, avs_readdatavalid, avs_readdata, exp[i]); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, exp; logic v;
    logic [18:0] a;
    int op, r;
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 2);
      r  = $urandom_range(0, 8);
      a  = (r == 8) ? 19'h7FFFF : 19'(r);
      wd = $urandom;
      exp = model_read(a);
      case (op)
        0: begin
          do_read(a, rd, v);
          n_total++; if (v !== 1'b1 || rd !== exp)
            $display("FAIL rand_read[%0d] a=%h: got %h vld %b want %h", it, a, rd, v, exp); else n_pass++;
        end
        1: begin
          do_write(a, wd);
          n_total++; if (video_enable !== m_ctrl[0] || fg_colour !== m_colour)
            $display("FAIL rand_write_out[%0d]: en %b col %h want %b/%h", it, video_enable, fg_colour, m_ctrl[0], m_colour); else n_pass++;
        end
        default: begin
          do_access(a, 1'b1, 1'b1, wd, rd, v);
          n_total++; if (v !== 1'b1 || rd !== exp)
            $display("FAIL rand_rw_prewrite[%0d] a=%h: got %h want %h", it, a, rd, exp); else n_pass++;
        end
      endcase
    end
    for (int a2 = 0; a2 < 6; a2++) begin
      do_read(19'(a2), rd, v);
      n_total++; if (rd !== model_read(19'(a2)))
        $display("FAIL rand_final_reg%0d: got %h want %h", a2, rd, model_read(19'(a2))); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic v;
    logic [31:0] exps [4] = '{32'h0, 32'h0000_FF00, 32'h0, 32'h0};
    logic [18:0] addrs [4] = '{19'd1, 19'd2, 19'd3, 19'd5};
    do_write(19'd5, 32'h1234_5678);
    do_write(19'd2, 32'h00AA_BBCC);
    do_write(19'd1, 32'h3);
    avs_address = 19'd0; avs_read = 1'b1;
    @(negedge pix_clk);
    avs_read = 1'b0;
    reset_n = 1'b0;
    #1;
    n_total++; if (avs_readdatavalid !== 1'b0 || avs_readdata !== 32'h0)
      $display("FAIL midreset_rd: vld %b data %h want 0/0", avs_readdatavalid, avs_readdata); else n_pass++;
    n_total++; if (video_enable !== 1'b0 || fg_colour !== 24'h00FF00)
      $display("FAIL midreset_out: en %b col %h want 0/00ff00", video_enable, fg_colour); else n_pass++;
    @(negedge pix_clk);
    n_total++; if (avs_readdatavalid !== 1'b0)
      $display("FAIL midreset_vld_held: vld %b want 0", avs_readdatavalid); else n_pass++;
    reset_n = 1'b1;
    model_reset();
    @(negedge pix_clk);
    foreach (addrs[i]) begin
      do_read(addrs[i], rd, v);
      n_total++; if (rd !== exps[i])
        $display("FAIL midreset_reg%0d: got %h want %h", addrs[i], rd, exps[i]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_colour_ctrl();
    test_frame_count();
    test_hpd();
    test_unmapped();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
